// File: rtl/vmem_scan_ctrl.sv
// Scan controller and port arbiter for the 16-lane vector data memory.
// Sequences burst scans of the image buffer (one vector per beat) and shares
// the single memory port with the CPU vector load/store path.
module vmem_scan_ctrl #(
    parameter int unsigned IMAGE_WIDTH  = 120,
    parameter int unsigned IMAGE_HEIGHT = 120,
    parameter int unsigned LANES        = 16,
    parameter int unsigned CNT_W        = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             op,
    input  logic [15:0]      base_addr,
    input  logic [CNT_W-1:0] vec_count,
    input  logic             abort,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [15:0]      cpu_addr,
    output logic             cpu_gnt,
    output logic             rd_valid,
    input  logic             rd_ready,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [15:0]      mem_addr,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] remaining
);

    localparam int unsigned ImagePixels = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned StarveW     = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t             state;
    logic               scan_op;
    logic [15:0]        cur_addr;
    logic [StarveW-1:0] starve_cnt;

    logic        scan_pend;
    logic        cpu_win;
    logic        beat;
    logic [16:0] end_addr;
    logic        start_bad;

    // Start-request bounds check, done in 17 bits so the sum cannot wrap.
    always_comb begin
        end_addr  = {1'b0, base_addr} + (17'(vec_count) * 17'(LANES));
        start_bad = (vec_count == '0) || (end_addr > 17'(ImagePixels));
    end

    // Arbitration and port muxing; RST forces the port to its idle value.
    always_comb begin
        scan_pend = ~scan_op | wr_valid;
        cpu_win   = cpu_req & ~(scan_pend & (starve_cnt == StarveW'(STARVE_LIMIT)));
        cpu_gnt   = 1'b0;
        rd_valid  = 1'b0;
        wr_ready  = 1'b0;
        mem_sel   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        beat      = 1'b0;
        if (!RST) begin
            unique case (state)
                StIdle, StDone: begin
                    if (cpu_req) begin
                        cpu_gnt = 1'b1;
                        mem_we  = cpu_we;
                    end
                end
                StRun: begin
                    if (cpu_win) begin
                        cpu_gnt = 1'b1;
                        mem_we  = cpu_we;
                    end else if (scan_pend) begin
                        mem_sel  = 1'b1;
                        mem_addr = cur_addr;
                        if (!scan_op) begin
                            rd_valid = 1'b1;
                            beat     = rd_ready;
                        end else begin
                            // scan_pend implies wr_valid for a write scan
                            wr_ready = 1'b1;
                            mem_we   = 1'b1;
                            beat     = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan FSM, address/beat counters, starvation counter and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= StIdle;
            scan_op    <= 1'b0;
            cur_addr   <= '0;
            starve_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            remaining  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        scan_op <= op;
                        if (start_bad) begin
                            err <= 1'b1;
                        end else begin
                            err        <= 1'b0;
                            cur_addr   <= base_addr;
                            remaining  <= vec_count;
                            starve_cnt <= '0;
                            busy       <= 1'b1;
                            state      <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (beat) begin
                        cur_addr  <= cur_addr + 16'(LANES);
                        remaining <= remaining - CNT_W'(1);
                    end
                    if (beat || !scan_pend) begin
                        starve_cnt <= '0;
                    end else if (cpu_win) begin
                        starve_cnt <= starve_cnt + StarveW'(1);
                    end
                    // abort wins over completion: no done pulse
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else if (beat && (remaining == CNT_W'(1))) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_scan_ctrl.sv
// Self-checking bench for vmem_scan_ctrl: directed scenarios plus randomized
// scans, compared each cycle against a queue-based reference model.
module tb_vmem_scan_ctrl;

    localparam int unsigned W   = 120;
    localparam int unsigned H   = 120;
    localparam int unsigned L   = 16;
    localparam int unsigned CW  = 10;
    localparam int unsigned SL  = 4;
    localparam int          PIX = W * H;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [15:0]   base_addr = '0;
    logic [CW-1:0] vec_count = '0;
    logic          abort = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [15:0]   cpu_addr = '0;
    logic          cpu_gnt;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [15:0]   mem_addr;
    logic          mem_we;
    logic          mem_sel;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] remaining;

    always #5 CLK = ~CLK;

    vmem_scan_ctrl #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .LANES       (L),
        .CNT_W       (CW),
        .STARVE_LIMIT(SL)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .op       (op),
        .base_addr(base_addr),
        .vec_count(vec_count),
        .abort    (abort),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_gnt  (cpu_gnt),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_sel  (mem_sel),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .remaining(remaining)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 scanning, 2 completion cycle.
    int m_ph = 0;
    bit m_op = 1'b0;
    int m_q[$];
    int m_starve = 0;
    bit m_err = 1'b0;
    int m_rem = 0;

    // Observations for directed checks.
    int obs_addr[$];
    int done_cnt = 0;
    int done_cyc = -1;
    int we_cnt = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model past the edge.
    task automatic cycle();
        bit pend, cpu, scan, beat;
        bit x_gnt, x_sel, x_we, x_rv, x_wr;
        int x_addr;
        #2;
        pend = 1'b0; cpu = 1'b0; scan = 1'b0; beat = 1'b0;
        x_gnt = 1'b0; x_sel = 1'b0; x_we = 1'b0; x_rv = 1'b0; x_wr = 1'b0;
        x_addr = int'(cpu_addr);
        if (!RST) begin
            if (m_ph == 1) begin
                pend = !m_op || wr_valid;
                cpu  = cpu_req && !(pend && m_starve == SL);
                scan = !cpu && pend;
                beat = scan && (m_op ? 1'b1 : rd_ready);
            end else begin
                cpu = cpu_req;
            end
            if (cpu) begin
                x_gnt = 1'b1;
                x_we  = cpu_we;
            end
            if (scan) begin
                x_sel  = 1'b1;
                x_addr = m_q[0];
                x_we   = m_op;
                x_rv   = !m_op;
                x_wr   = m_op;
            end
        end
        chk("cpu_gnt", 32'(cpu_gnt), 32'(x_gnt));
        chk("mem_sel", 32'(mem_sel), 32'(x_sel));
        chk("mem_addr", 32'(mem_addr), x_addr);
        chk("mem_we", 32'(mem_we), 32'(x_we));
        chk("rd_valid", 32'(rd_valid), 32'(x_rv));
        chk("wr_ready", 32'(wr_ready), 32'(x_wr));
        chk("busy", 32'(busy), 32'(m_ph != 0));
        chk("done", 32'(done), 32'(m_ph == 2));
        chk("err", 32'(err), 32'(m_err));
        chk("remaining", 32'(remaining), m_rem);
        if (mem_sel === 1'b1) obs_addr.push_back(int'(mem_addr));
        if (mem_we === 1'b1) we_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge CLK);
        if (RST) begin
            m_ph = 0; m_err = 1'b0; m_rem = 0; m_starve = 0; m_q.delete();
        end else if (m_ph == 0) begin
            if (start) begin
                if (vec_count == 0 || int'(base_addr) + int'(vec_count) * L > PIX) begin
                    m_err = 1'b1;
                end else begin
                    m_err = 1'b0;
                    m_op  = op;
                    m_q.delete();
                    for (int k = 0; k < int'(vec_count); k++) m_q.push_back(int'(base_addr) + k * L);
                    m_rem    = int'(vec_count);
                    m_starve = 0;
                    m_ph     = 1;
                end
            end
        end else if (m_ph == 1) begin
            if (beat) begin
                void'(m_q.pop_front());
                m_rem--;
            end
            if (beat || !pend) m_starve = 0;
            else if (cpu) m_starve++;
            if (abort) m_ph = 0;
            else if (beat && m_q.size() == 0) m_ph = 2;
        end else begin
            m_ph = 0;
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic quiet();
        start = 1'b0; abort = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        rd_ready = 1'b0; wr_valid = 1'b0;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        done_cnt = 0;
        done_cyc = -1;
        we_cnt = 0;
        cyc = 0;
    endtask

    task automatic start_scan(input bit o, input int b, input int c);
        start = 1'b1;
        op = o;
        base_addr = 16'(b);
        vec_count = CW'(c);
        cycle();
        start = 1'b0;
    endtask

    task automatic run_random(input int budget);
        int guard;
        guard = 0;
        while (m_ph != 0 && guard < budget) begin
            cpu_req  = ($urandom_range(0, 99) < 40);
            cpu_we   = $urandom_range(0, 1) == 1;
            cpu_addr = 16'($urandom);
            rd_ready = ($urandom_range(0, 99) < 70);
            wr_valid = ($urandom_range(0, 99) < 70);
            abort    = ($urandom_range(0, 63) == 0);
            start    = ($urandom_range(0, 15) == 0);
            base_addr = 16'($urandom);
            vec_count = CW'($urandom);
            cycle();
            guard++;
        end
        quiet();
        if (guard >= budget) chk("scan_timeout", 32'(guard), 32'(budget - 1));
    endtask

    initial begin
        int b, c;
        quiet();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        cycle();
        RST = 1'b0;
        cycle();
        chk("reset_remaining", 32'(remaining), 0);
        chk("reset_busy", 32'(busy), 0);

        // Read scan, base 0, 4 vectors, no CPU traffic.
        clear_obs();
        rd_ready = 1'b1;
        start_scan(1'b0, 0, 4);
        repeat (6) cycle();
        chk("rd_nbeats", 32'(obs_addr.size()), 4);
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) chk("rd_addr", obs_addr[i], i * 16);
        chk("rd_done_cyc", done_cyc, 5);
        chk("rd_done_cnt", done_cnt, 1);
        quiet();

        // Write scan, 3 vectors, wr_valid 1,0,1,1.
        clear_obs();
        start_scan(1'b1, 160, 3);
        wr_valid = 1'b1; cycle();
        wr_valid = 1'b0; cycle();
        wr_valid = 1'b1; cycle();
        cycle();
        wr_valid = 1'b0;
        repeat (2) cycle();
        chk("wr_nwe", we_cnt, 3);
        chk("wr_nbeats", 32'(obs_addr.size()), 3);
        for (int i = 0; i < 3 && i < obs_addr.size(); i++) chk("wr_addr", obs_addr[i], 160 + i * 16);
        chk("wr_done_cyc", done_cyc, 5);

        // Read scan against a CPU that never lets go.
        clear_obs();
        cpu_req = 1'b1;
        cpu_addr = 16'h1234;
        rd_ready = 1'b1;
        start_scan(1'b0, 64, 3);
        repeat (17) begin
            cpu_we = $urandom_range(0, 1) == 1;
            cycle();
        end
        chk("starve_nbeats", 32'(obs_addr.size()), 3);
        chk("starve_done_cyc", done_cyc, 16);
        quiet();
        cycle();

        // Out-of-range start, then a valid one at the exact top of the image.
        clear_obs();
        start_scan(1'b0, 14390, 1);
        chk("oob_err", 32'(err), 1);
        chk("oob_busy", 32'(busy), 0);
        repeat (2) cycle();
        chk("oob_noaccess", 32'(obs_addr.size()), 0);
        rd_ready = 1'b1;
        start_scan(1'b0, 14384, 1);
        chk("fit_err_clear", 32'(err), 0);
        repeat (3) cycle();
        chk("fit_addr", obs_addr.size() > 0 ? obs_addr[0] : -1, 14384);
        quiet();

        // Abort after 2 of 8 beats.
        clear_obs();
        rd_ready = 1'b1;
        start_scan(1'b0, 320, 8);
        repeat (2) cycle();
        rd_ready = 1'b0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        repeat (3) cycle();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_remaining", 32'(remaining), 6);
        chk("abort_done_cnt", done_cnt, 0);

        // Reset in the middle of a scan.
        rd_ready = 1'b1;
        start_scan(1'b1, 480, 8);
        wr_valid = 1'b1;
        repeat (3) cycle();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        quiet();
        cycle();
        chk("rst_remaining", 32'(remaining), 0);
        chk("rst_busy", 32'(busy), 0);

        // start while a scan is running is ignored.
        clear_obs();
        rd_ready = 1'b1;
        start_scan(1'b0, 480, 4);
        cycle();
        start_scan(1'b1, 0, 2);
        repeat (4) cycle();
        chk("busy_start_nbeats", 32'(obs_addr.size()), 4);
        for (int i = 0; i < 4 && i < obs_addr.size(); i++)
            chk("busy_start_addr", obs_addr[i], 480 + i * 16);
        chk("busy_start_done_cyc", done_cyc, 5);
        quiet();

        // Boundary counts: zero, oversize, exact full-image fit.
        start_scan(1'b0, 0, 0);
        chk("zero_count_err", 32'(err), 1);
        start_scan(1'b0, 0, 1023);
        chk("max_count_err", 32'(err), 1);
        start_scan(1'b0, 0, 901);
        chk("over_count_err", 32'(err), 1);
        clear_obs();
        rd_ready = 1'b1;
        start_scan(1'b0, 0, 900);
        repeat (901) cycle();
        chk("full_done_cyc", done_cyc, 901);
        chk("full_last_addr", obs_addr.size() == 900 ? obs_addr[899] : -1, 14384);
        quiet();
        cycle();

        // Randomized scans against the model.
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(PIX - 64, 65535);
                c = $urandom_range(0, 8);
            end else begin
                c = $urandom_range(1, 40);
                b = $urandom_range(0, PIX - c * L);
            end
            cpu_req  = $urandom_range(0, 1) == 1;
            cpu_addr = 16'($urandom);
            start_scan($urandom_range(0, 1) == 1, b, c);
            run_random(4000);
            repeat ($urandom_range(0, 2)) cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vmem_scan_ctrl.md
# vmem_scan_ctrl

Controller and arbiter for the 16-lane vector data memory port. Sequences burst scans of the image buffer, one 16-pixel vector per beat, for loading or dumping the image. Shares the single memory port with the CPU vector load/store path. Sits between the CPU memory stage, the image stream interface and the vector data memory; it drives only address, write-enable and the data-mux select, not the data itself.

## Interface
- IMAGE_WIDTH, 120, image width in pixels
- IMAGE_HEIGHT, 120, image height in pixels
- LANES, 16, pixels per vector beat; the address step per beat
- CNT_W, 10, width of the vector-count field
- STARVE_LIMIT, 4, maximum consecutive CPU grants while a scan beat is pending
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  one-cycle scan request; honoured only in IDLE
- op  in  1  scan direction: 0 = read scan (memory -> stream), 1 = write scan (stream -> memory)
- base_addr  in  16  first vector address of the scan
- vec_count  in  CNT_W  number of vectors in the scan
- abort  in  1  terminate the active scan
- cpu_req  in  1  CPU memory access request
- cpu_we  in  1  CPU write strobe
- cpu_addr  in  16  CPU vector address
- cpu_gnt  out  1  CPU owns the port this cycle
- rd_valid  out  1  read-scan beat available on the memory RD bus
- rd_ready  in  1  stream consumer accepts the read beat
- wr_valid  in  1  write-scan beat present on the stream
- wr_ready  out  1  write-scan beat is written this cycle
- mem_addr  out  16  to memory Addr
- mem_we  out  1  to memory WE
- mem_sel  out  1  WD/RD mux select: 0 = CPU, 1 = scanner
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse on scan completion
- err  out  1  sticky: last start was rejected
- remaining  out  CNT_W  beats left in the current scan

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - busy=0; cpu_gnt=cpu_req.
  - On start, latch op, base_addr and vec_count.
  - If vec_count==0 or base_addr + vec_count*LANES > IMAGE_WIDTH*IMAGE_HEIGHT (17-bit compare), set err=1 and stay in IDLE.
  - Otherwise clear err, set cur_addr=base_addr and remaining=vec_count, and go to RUN.
- RUN arbitration, decided each cycle
  - scan_pend = (op==0) or wr_valid.
  - The CPU wins if cpu_req is high and not (scan_pend and starve_cnt==STARVE_LIMIT).
  - starve_cnt increments on each CPU grant while scan_pend is high.
  - It clears on any scanner beat and on any cycle where scan_pend is low.
- Scanner owns the port (mem_sel=1, mem_addr=cur_addr)
  - Read scan: rd_valid=1. Beat completes when rd_ready=1.
  - Write scan: wr_ready=wr_valid, mem_we=wr_valid. Beat completes when wr_valid=1.
  - On each beat: cur_addr += LANES, remaining -= 1.
  - A beat that makes remaining 0 moves to DONE.
- CPU owns the port: mem_sel=0, mem_addr=cpu_addr, mem_we=cpu_we, rd_valid=0, wr_ready=0.
- DONE: done=1 and busy=1 for one cycle, then IDLE. The CPU may be granted in DONE.
- abort in RUN: go to IDLE next cycle. No done, err unchanged; a beat in that same cycle still completes.
- start outside IDLE is ignored.
- Port idle (no owner): mem_sel=0, mem_addr=cpu_addr, mem_we=0.

## Timing
- Reset values: state IDLE; busy, done, err, cpu_gnt, rd_valid, wr_ready, mem_we and mem_sel all 0; remaining=0; starve_cnt=0.
- RST during RUN aborts the scan with no done.
- start -> busy=1 on the next cycle; first beat possible in that cycle.
- The RD bus is combinational, so rd_valid and its data share a cycle. Write data is captured by the memory on the falling edge of the beat cycle.
- Throughput: 1 beat/cycle with no CPU traffic. Scan of N vectors with no stalls: busy for N+1 cycles (done in cycle N+1).
- All port outputs (mem_*, cpu_gnt, rd_valid, wr_ready) are combinational from state and inputs; state, counters and flags are registered.
- vec_count = 2^CNT_W-1 is allowed if within bounds. cur_addr never exceeds IMAGE_WIDTH*IMAGE_HEIGHT.

## Test plan
- Read scan, base=0, count=4, rd_ready=1, no CPU: mem_addr 0,16,32,48 on consecutive cycles, mem_sel=1, done on the 5th cycle after start, remaining 4→0.
- Write scan, count=3, wr_valid toggling 1,0,1,1: mem_we only on valid cycles, addresses base, base+16, base+32; done after the last write.
- Read scan with cpu_req held high: CPU granted 4 cycles, then one scanner beat, repeating; starve_cnt resets after each beat; scan completes.
- Start with base=14390, count=1 (14406 > 14400): err=1, busy stays 0, no memory access. A following valid start clears err.
- Abort after 2 of 8 beats: IDLE next cycle, done never pulses, remaining frozen at 6 until the next start. RST mid-scan gives all outputs at reset values.
- start while busy: ignored, and the current scan's addresses are unchanged.
